// File: rtl/ram_row_reader.sv
// Read-side master for the row RAM: sweeps a run of row addresses and streams each row
// out on a valid/ready port via a 2-entry FIFO. Define RAM_ROW_READER_LAST_EN for out_last.
module ram_row_reader #(
   parameter int BIT_WIDTH     = 32,
   parameter int RAM_WIDTH     = 4,
   parameter int RAM_ADDR_BITS = 10
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           start,
   input  logic [RAM_ADDR_BITS-1:0]       base_addr,
   input  logic [RAM_ADDR_BITS:0]         length,
   output logic                           busy,
   output logic                           done,
   output logic [RAM_ADDR_BITS-1:0]       rdaddress,
   input  logic [BIT_WIDTH*RAM_WIDTH-1:0] q,
   output logic [BIT_WIDTH*RAM_WIDTH-1:0] out_data,
   output logic                           out_valid,
   input  logic                           out_ready
`ifdef RAM_ROW_READER_LAST_EN
   ,
   output logic                           out_last
`endif
);

   localparam int RowW = BIT_WIDTH * RAM_WIDTH;
   localparam logic [RAM_ADDR_BITS:0]   CntOne  = 1;
   localparam logic [RAM_ADDR_BITS-1:0] AddrOne = 1;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN
   } state_t;

   state_t                   state_q;
   logic [RAM_ADDR_BITS:0]   len_q;
   logic [RAM_ADDR_BITS:0]   issued_q;
   logic [RAM_ADDR_BITS-1:0] rdaddr_q;
   logic                     busy_q;
   logic                     done_q;
   logic [1:0]               cnt_q;
   logic [1:0]               cnt_d;
   logic                     valid_q;
   logic [RowW-1:0]          head_q;
   logic [RowW-1:0]          tail_q;
   logic                     push;
   logic                     pop;
   logic                     lastPush;
`ifdef RAM_ROW_READER_LAST_EN
   logic                     headLast_q;
   logic                     tailLast_q;
`endif

   // The head register is the output stage, so a stalled beat holds by construction.
   always_comb begin
      push     = (state_q == READ) && (cnt_q != 2'd2) && (issued_q != len_q);
      pop      = valid_q && out_ready;
      lastPush = (issued_q + CntOne) == len_q;
      cnt_d    = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + 2'd1;
      end else if (!push && pop) begin
         cnt_d = cnt_q - 2'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         len_q      <= '0;
         issued_q   <= '0;
         rdaddr_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cnt_q      <= 2'd0;
         valid_q    <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
`ifdef RAM_ROW_READER_LAST_EN
         headLast_q <= 1'b0;
         tailLast_q <= 1'b0;
`endif
      end else begin
         done_q  <= 1'b0;
         cnt_q   <= cnt_d;
         valid_q <= (cnt_d != 2'd0);

         // A new row lands in head when the FIFO is (or becomes) empty, else in tail.
         if (push && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) begin
            head_q <= q;
`ifdef RAM_ROW_READER_LAST_EN
            headLast_q <= lastPush;
`endif
         end else if (pop && cnt_q == 2'd2) begin
            head_q <= tail_q;
`ifdef RAM_ROW_READER_LAST_EN
            headLast_q <= tailLast_q;
`endif
         end
         if (push && cnt_q == 2'd1 && !pop) begin
            tail_q <= q;
`ifdef RAM_ROW_READER_LAST_EN
            tailLast_q <= lastPush;
`endif
         end
         if (push) begin
            issued_q <= issued_q + CntOne;
            rdaddr_q <= rdaddr_q + AddrOne;
         end

         case (state_q)
            IDLE: begin
               if (start) begin
                  if (length == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     len_q    <= length;
                     issued_q <= '0;
                     rdaddr_q <= base_addr;
                     busy_q   <= 1'b1;
                     state_q  <= READ;
                  end
               end
            end
            READ: begin
               if (push && lastPush) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (cnt_d == 2'd0) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign rdaddress = rdaddr_q;
   assign out_data  = head_q;
   assign out_valid = valid_q;
`ifdef RAM_ROW_READER_LAST_EN
   assign out_last  = headLast_q && valid_q;
`endif

endmodule

// File: tb/tb_ram_row_reader.sv
// Randomized self-checking bench for ram_row_reader against a queue-based model of the
// expected row stream, plus directed runs with literal expectations.
module tb_ram_row_reader;

   localparam int AB    = 10;
   localparam int DEPTH = 1 << AB;
   localparam int ROWW  = 128;

   logic            clock = 1'b0;
   logic            reset_n = 1'b1;
   logic            start = 1'b0;
   logic [AB-1:0]   base_addr = '0;
   logic [AB:0]     length = '0;
   logic            busy;
   logic            done;
   logic [AB-1:0]   rdaddress;
   logic [ROWW-1:0] q;
   logic [ROWW-1:0] out_data;
   logic            out_valid;
   logic            out_ready = 1'b1;
`ifdef RAM_ROW_READER_LAST_EN
   logic            out_last;
`endif

   logic [ROWW-1:0] mem [DEPTH];
   assign q = mem[rdaddress];

   ram_row_reader #(.BIT_WIDTH(32), .RAM_WIDTH(4), .RAM_ADDR_BITS(AB)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .length(length), .busy(busy), .done(done), .rdaddress(rdaddress), .q(q),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef RAM_ROW_READER_LAST_EN
      , .out_last(out_last)
`endif
   );

   always #5 clock = ~clock;

   int compared = 0;
   int mismatched = 0;
   int cycleCnt = 0;
   int readyMode = 0;
   int patIdx = 0;
   bit pat [8] = '{1, 0, 0, 1, 0, 1, 1, 0};

   int expq [$];
   bit active = 0;
   int sinceAccept = 0;
   bit expDone = 0;
   bit prevStall = 0;
   logic [ROWW-1:0] prevData = '0;
   bit beat;
   bit expValid;
   int popAddr;
   int beatWord [$];
   int beatCyc [$];
   int doneCyc [$];

   function automatic logic [ROWW-1:0] rowOf(input int k);
      return {32'(32'hC0DE0000 + k), 32'(k * 3 + 1), 32'(k ^ 32'h5A5A0000), 32'(k)};
   endfunction

   task automatic checkOutput(input string name, input logic [ROWW-1:0] act,
                              input logic [ROWW-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycleCnt);
      end
   endtask

   always @(posedge clock) cycleCnt++;

   // Ready patterns: always high, a fixed toggle table, or random.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         case (readyMode)
            0: out_ready = 1'b1;
            1: begin out_ready = pat[patIdx % 8]; patIdx++; end
            default: out_ready = ($urandom_range(99) < 70);
         endcase
      end
   end

   // Model: a queue of the row addresses still owed, plus the done/busy timing rules.
   always @(negedge clock) begin
      if (!reset_n) begin
         expq.delete();
         active = 0;
         expDone = 0;
         prevStall = 0;
         sinceAccept = 0;
      end else begin
         checkOutput("done", done, expDone);
         checkOutput("busy", busy, active);
         expValid = active && sinceAccept >= 1 && expq.size() > 0;
         checkOutput("out_valid", out_valid, expValid);
         if (prevStall) checkOutput("hold_data", out_data, prevData);
`ifdef RAM_ROW_READER_LAST_EN
         checkOutput("out_last", out_last, expValid && expq.size() == 1);
`endif
         beat = out_valid && out_ready;
         if (done) doneCyc.push_back(cycleCnt);
         if (beat) begin
            beatWord.push_back(int'(out_data[31:0]));
            beatCyc.push_back(cycleCnt);
            if (expq.size() == 0) begin
               checkOutput("extra_beat", 1, 0);
            end else begin
               popAddr = expq.pop_front();
               checkOutput("row_data", out_data, rowOf(popAddr));
            end
         end
         expDone = 0;
         if (active) begin
            sinceAccept++;
            if (beat && expq.size() == 0) begin
               active = 0;
               expDone = 1;
            end
         end else if (start) begin
            if (length == '0) begin
               expDone = 1;
            end else begin
               active = 1;
               sinceAccept = 0;
               for (int i = 0; i < int'(length); i++) expq.push_back((int'(base_addr) + i) % DEPTH);
            end
         end
         prevStall = out_valid && !out_ready;
         prevData = out_data;
      end
   end

   task automatic clearLogs();
      beatWord.delete();
      beatCyc.delete();
      doneCyc.delete();
   endtask

   task automatic applyStimulus(input int b, input int l, output int acceptEdge);
      @(posedge clock);
      #1;
      start = 1'b1;
      base_addr = AB'(b);
      length = (AB + 1)'(l);
      acceptEdge = cycleCnt + 1;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input int target, input int budget, input string name);
      int n = 0;
      while (doneCyc.size() < target && n < budget) begin
         @(negedge clock);
         #1;
         n++;
      end
      if (doneCyc.size() < target) checkOutput({name, "_timeout"}, 0, 1);
      repeat (2) @(negedge clock);
      #1;
   endtask

   task automatic checkWords(input string name, input int exp [$]);
      checkOutput({name, "_count"}, beatWord.size(), exp.size());
      for (int i = 0; i < exp.size() && i < beatWord.size(); i++)
         checkOutput({name, "_row"}, beatWord[i], exp[i]);
   endtask

   initial begin
      int e;
      int n;
      int b;
      int l;
      for (int k = 0; k < DEPTH; k++) mem[k] = rowOf(k);

      #2 reset_n = 1'b0;
      #1;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_valid", out_valid, 0);
      checkOutput("rst_data", out_data, 0);
      checkOutput("rst_addr", rdaddress, 0);
      repeat (2) @(posedge clock);
      #2 reset_n = 1'b1;

      // Basic sweep: rows 5..8 back to back, done one edge after the 4th beat.
      clearLogs();
      applyStimulus(5, 4, e);
      waitDone(1, 40, "t1");
      checkWords("t1", '{5, 6, 7, 8});
      for (int i = 0; i < 4 && i < beatCyc.size(); i++) checkOutput("t1_beat_cycle", beatCyc[i], e + 1 + i);
      if (doneCyc.size() > 0) checkOutput("t1_done_cycle", doneCyc[0], e + 5);

      // Same sweep under a stalling consumer.
      readyMode = 1;
      patIdx = 0;
      clearLogs();
      applyStimulus(5, 4, e);
      waitDone(1, 60, "t2");
      checkWords("t2", '{5, 6, 7, 8});

      // Address wrap at the top of the RAM.
      readyMode = 0;
      clearLogs();
      applyStimulus(1022, 4, e);
      waitDone(1, 40, "t3");
      checkWords("t3", '{1022, 1023, 0, 1});
      checkOutput("t3_rdaddr", rdaddress, 2);

      // Zero-length command.
      clearLogs();
      applyStimulus(7, 0, e);
      waitDone(1, 20, "t4");
      checkOutput("t4_beats", beatWord.size(), 0);
      if (doneCyc.size() > 0) checkOutput("t4_done_cycle", doneCyc[0], e);

      // Reset in the middle of a transfer, then a fresh command.
      clearLogs();
      applyStimulus(100, 8, e);
      n = 0;
      while (beatWord.size() < 2 && n < 40) begin
         @(negedge clock);
         #1;
         n++;
      end
      if (beatWord.size() < 2) checkOutput("t5_wait_timeout", 0, 1);
      #1 reset_n = 1'b0;
      #1;
      checkOutput("t5_busy", busy, 0);
      checkOutput("t5_valid", out_valid, 0);
      checkOutput("t5_data", out_data, 0);
      checkOutput("t5_addr", rdaddress, 0);
      checkOutput("t5_done", done, 0);
      repeat (3) @(negedge clock);
      checkOutput("t5_no_done", doneCyc.size(), 0);
      checkOutput("t5_beats", beatWord.size(), 2);
      @(posedge clock);
      #2 reset_n = 1'b1;
      clearLogs();
      applyStimulus(0, 2, e);
      waitDone(1, 30, "t5b");
      checkWords("t5b", '{0, 1});

      // start ignored while busy; start held through the done cycle launches the next run.
      clearLogs();
      applyStimulus(20, 3, e);
      @(posedge clock);
      #1;
      start = 1'b1;
      base_addr = AB'(300);
      length = (AB + 1)'(5);
      @(posedge clock);
      #1;
      base_addr = AB'(40);
      length = (AB + 1)'(2);
      n = 0;
      while (doneCyc.size() == 0 && n < 40) begin
         @(posedge clock);
         #1;
         n++;
      end
      start = 1'b0;
      waitDone(2, 40, "t6");
      checkWords("t6", '{20, 21, 22, 40, 41});
      checkOutput("t6_dones", doneCyc.size(), 2);
      if (doneCyc.size() > 0 && beatCyc.size() > 3) checkOutput("t6_relaunch", beatCyc[3], doneCyc[0] + 2);

      // Random commands with a random consumer.
      readyMode = 2;
      for (int t = 0; t < 25; t++) begin
         b = $urandom_range(DEPTH - 1);
         l = ($urandom_range(9) == 0) ? 0 : $urandom_range(12, 1);
         clearLogs();
         applyStimulus(b, l, e);
         waitDone(1, 400, "rand");
         checkOutput("rand_beats", beatWord.size(), l);
      end

      // Full-depth sweep.
      readyMode = 0;
      b = $urandom_range(DEPTH - 1);
      clearLogs();
      applyStimulus(b, DEPTH, e);
      waitDone(1, DEPTH + 100, "full");
      checkOutput("full_beats", beatWord.size(), DEPTH);
      if (beatWord.size() == DEPTH) begin
         checkOutput("full_first", beatWord[0], b);
         checkOutput("full_last", beatWord[DEPTH - 1], (b + DEPTH - 1) % DEPTH);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
